rc_charge_sequencer: RTL
========================

# rc_charge_sequencer

Shared-stimulus controller for the RC filter channels of the neuron front end. Up to N_CH channels request an RC charge-time measurement; a round-robin arbiter grants one channel at a time, the block drives that channel's step input high, times the cycles until the channel's threshold comparator fires, then holds the step low for a fixed discharge interval before releasing the grant. Measured delay and status are reported per transaction with a one-cycle done pulse.

## Interface
- N_CH, 4: number of RC channels / requesters (2..8)
- CNT_W, 8: width of delay counter and result
- TIMEOUT_CYC, 200: maximum CHARGE cycles before timeout (< 2^CNT_W)
- DISCHARGE_CYC, 32: cycles step held low after measurement (>= 1)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_CH  per-channel measurement request, level; sampled only in IDLE
- cmp_in  in  N_CH  per-channel comparator output (asynchronous to clk)
- grant  out  N_CH  one-hot channel currently served; all-zero in IDLE
- step_out  out  N_CH  one-hot step drive to the granted channel's RC input
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, result fields valid in that cycle and held until next done
- done_ch  out  $clog2(N_CH)  index of channel just completed
- delay  out  CNT_W  measured charge delay in clk cycles
- status  out  2  00 ok, 01 timeout, 10 pre-charged

## Operation
- States: IDLE, CHARGE, DISCHARGE, DONE.
- cmp_in synchronised per channel with two flops; only the synchronised value (cmp_s) is used.
- IDLE: if any req bit set, pick first set bit at or after rr_ptr (wrapping); load grant, clear counter, go CHARGE. No req: stay.
- CHARGE: step_out = grant; counter increments each cycle starting at 0 in first CHARGE cycle.
  - First CHARGE cycle with cmp_s[granted] already high: delay=0, status=10, go DISCHARGE.
  - Later cycle with cmp_s[granted] high: delay = counter value of that cycle, status=00, go DISCHARGE.
  - counter == TIMEOUT_CYC-1 without cmp: delay = all-ones, status=01, go DISCHARGE. Cmp and timeout in the same cycle: cmp wins (status 00).
- DISCHARGE: step_out = 0, grant held; counter reloaded, stays DISCHARGE_CYC cycles, then DONE.
- DONE: done=1 one cycle, done_ch=granted index, rr_ptr = granted index + 1 (mod N_CH); next IDLE, grant cleared.
- req changes while busy are ignored; a dropped req does not abort the transaction. A still-high req of the served channel is eligible again but ranks last.
- Only one step_out bit is ever high; step_out high only in CHARGE.

## Timing
- Reset (async assert, sync deassert by clk): state IDLE, rr_ptr 0, grant 0, step_out 0, busy 0, done 0, done_ch 0, delay 0, status 00, sync flops 0.
- Reset mid-transaction: step_out drops immediately (asynchronously); no done issued.
- req high in IDLE at edge t -> grant/step_out/busy high from t+1.
- cmp_in rising before edge of CHARGE cycle k (k=0 first) -> cmp_s seen in cycle k+2 -> delay = k+2; transition at end of that cycle.
- Transaction length = (delay+1) CHARGE cycles + DISCHARGE_CYC + 1 DONE cycle; next grant earliest one cycle after DONE (IDLE cycle in between).
- delay/status/done_ch registered, update in the DONE cycle only.

## Test plan
- Single req[2], cmp_in[2] rises 10 cycles after step_out -> delay=12, status=00, done_ch=2, done one cycle, grant released after 32 DISCHARGE cycles.
- req=4'b1111 held continuously -> grants 0,1,2,3,0 in order, each done reports matching done_ch, step_out never multi-hot.
- Granted channel cmp_in never rises -> after 200 CHARGE cycles delay=8'hFF, status=01, step_out low during discharge.
- cmp_in[1] held high before req[1] -> delay=0, status=10 after cmp_s asserts in first CHARGE cycle (cmp pre-settled two cycles), full discharge still performed.
- cmp rising exactly on timeout cycle -> status=00, delay=199.
- rst_n asserted mid-CHARGE -> step_out, grant, busy low without clock edge; after release, pending req served from channel 0, no spurious done.

Source files
------------

// File: rtl/rc_charge_sequencer.sv
// Round-robin RC charge-time sequencer: grants one channel, drives its step input,
// times the comparator response, then discharges before reporting the result.
module rc_charge_sequencer #(
    parameter int N_CH          = 4,
    parameter int CNT_W         = 8,
    parameter int TIMEOUT_CYC   = 200,
    parameter int DISCHARGE_CYC = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         req,
    input  logic [N_CH-1:0]         cmp_in,
    output logic [N_CH-1:0]         grant,
    output logic [N_CH-1:0]         step_out,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(N_CH)-1:0] done_ch,
    output logic [CNT_W-1:0]        delay,
    output logic [1:0]              status
);

    localparam int PTR_W = $clog2(N_CH);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_PRECHG  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CHARGE,
        DISCHARGE,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N_CH-1:0]    cmp_meta_q, cmp_s_q;
    logic [N_CH-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   meas_delay_q, meas_delay_d;
    logic [1:0]         meas_status_q, meas_status_d;
    logic [CNT_W-1:0]   delay_q, delay_d;
    logic [1:0]         status_q, status_d;
    logic [PTR_W-1:0]   done_ch_q, done_ch_d;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand;
    logic               cmp_hit;

    // Comparator outputs are asynchronous; only the second flop stage is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_meta_q <= '0;
            cmp_s_q    <= '0;
        end else begin
            cmp_meta_q <= cmp_in;
            cmp_s_q    <= cmp_meta_q;
        end
    end

    // First requester at or after rr_ptr, wrapping; the last served channel ranks last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = PTR_W'((int'(rr_ptr_q) + i) % N_CH);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign cmp_hit = cmp_s_q[gnt_idx_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            gnt_idx_q     <= '0;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            meas_delay_q  <= '0;
            meas_status_q <= ST_OK;
            delay_q       <= '0;
            status_q      <= ST_OK;
            done_ch_q     <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            gnt_idx_q     <= gnt_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            meas_delay_q  <= meas_delay_d;
            meas_status_q <= meas_status_d;
            delay_q       <= delay_d;
            status_q      <= status_d;
            done_ch_q     <= done_ch_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gnt_idx_d     = gnt_idx_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        meas_delay_d  = meas_delay_q;
        meas_status_d = meas_status_q;
        delay_d       = delay_q;
        status_d      = status_q;
        done_ch_d     = done_ch_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d   = {{(N_CH-1){1'b0}}, 1'b1} << pick_idx;
                    gnt_idx_d = pick_idx;
                    cnt_d     = '0;
                    state_d   = CHARGE;
                end
            end
            CHARGE: begin
                cnt_d = cnt_q + 1'b1;
                // A comparator hit takes priority over a timeout in the same cycle.
                if (cmp_hit) begin
                    meas_delay_d  = cnt_q;
                    meas_status_d = (cnt_q == '0) ? ST_PRECHG : ST_OK;
                    cnt_d         = '0;
                    state_d       = DISCHARGE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    meas_delay_d  = '1;
                    meas_status_d = ST_TIMEOUT;
                    cnt_d         = '0;
                    state_d       = DISCHARGE;
                end
            end
            DISCHARGE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DISCHARGE_CYC - 1)) begin
                    delay_d   = meas_delay_q;
                    status_d  = meas_status_q;
                    done_ch_d = gnt_idx_q;
                    state_d   = DONE;
                end
            end
            DONE: begin
                rr_ptr_d = (gnt_idx_q == PTR_W'(N_CH - 1)) ? '0 : gnt_idx_q + 1'b1;
                grant_d  = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoded from the async-reset state so the step drive drops the moment reset asserts.
    assign step_out = (state_q == CHARGE) ? grant_q : '0;
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign done_ch  = done_ch_q;
    assign delay    = delay_q;
    assign status   = status_q;

endmodule
